// File: rtl/snake_segment_streamer.sv
// Walks a snapshot of snake segments (head first, then body, optionally food) out as grid cells.
// Latency: first cell valid the cycle after start acceptance; one cell per cycle with out_ready high.
// Backpressure: out_valid/out_ready handshake; the presented cell holds stable while out_ready is low.
module snake_segment_streamer #(
  parameter int COORD_W = 4,
  parameter int MAX_LEN = 225,
  parameter int LEN_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [MAX_LEN*2*COORD_W-1:0] snake_in,
  input  logic [LEN_W-1:0]           length,
  input  logic                       food_en,
  input  logic [COORD_W-1:0]         xfood,
  input  logic [COORD_W-1:0]         yfood,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [COORD_W-1:0]         x_loc,
  output logic [COORD_W-1:0]         y_loc,
  output logic [1:0]                 data_out,
  output logic                       busy,
  output logic                       done,
  output logic                       len_err
);

  localparam int SEG_W = 2 * COORD_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEG  = 2'd1;
  localparam logic [1:0] FOOD = 2'd2;

  localparam logic [1:0] CODE_HEAD = 2'b11;
  localparam logic [1:0] CODE_BODY = 2'b10;
  localparam logic [1:0] CODE_FOOD = 2'b01;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  // Walk state and snapshot
  logic [1:0]                 state_q, state_d;
  logic [LEN_W-1:0]           idx_q, idx_d;
  logic [LEN_W-1:0]           len_q, len_d;
  logic [MAX_LEN*SEG_W-1:0]   snake_q, snake_d;
  logic                       food_en_q, food_en_d;
  logic [COORD_W-1:0]         xfood_q, xfood_d;
  logic [COORD_W-1:0]         yfood_q, yfood_d;

  // Registered outputs
  logic                       valid_q, valid_d;
  logic [COORD_W-1:0]         x_q, x_d;
  logic [COORD_W-1:0]         y_q, y_d;
  logic [1:0]                 code_q, code_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       len_err_q, len_err_d;

  logic                       len_over;
  logic [LEN_W-1:0]           len_clamped;
  logic [LEN_W-1:0]           idx_next;
  logic [LEN_W-1:0]           idx_sel;
  logic [SEG_W-1:0]           seg_in0;
  logic [SEG_W-1:0]           seg_nxt;
  logic                       last_seg;

  // Length clamping and next-segment lookup; idx_sel keeps the read inside the snapshot
  always_comb begin
    len_over    = (length > MAX_LEN_L);
    len_clamped = len_over ? MAX_LEN_L : length;
    idx_next    = idx_q + 1'b1;
    idx_sel     = (idx_next < MAX_LEN_L) ? idx_next : '0;
    seg_in0     = snake_in[SEG_W-1:0];
    seg_nxt     = snake_q[SEG_W*int'(idx_sel) +: SEG_W];
    last_seg    = (idx_q == len_q - 1'b1);
  end

  // Next-state logic: segment 0 comes straight from the inputs on acceptance so the
  // head is valid the very next cycle, before the snapshot is readable.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    snake_d   = snake_q;
    food_en_d = food_en_q;
    xfood_d   = xfood_q;
    yfood_d   = yfood_q;
    valid_d   = valid_q;
    x_d       = x_q;
    y_d       = y_q;
    code_d    = code_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    len_err_d = len_err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          snake_d   = snake_in;
          len_d     = len_clamped;
          food_en_d = food_en;
          xfood_d   = xfood;
          yfood_d   = yfood;
          idx_d     = '0;
          len_err_d = len_over;
          busy_d    = 1'b1;
          if (len_clamped != '0) begin
            state_d = SEG;
            valid_d = 1'b1;
            x_d     = seg_in0[COORD_W-1:0];
            y_d     = seg_in0[SEG_W-1:COORD_W];
            code_d  = CODE_HEAD;
          end else if (food_en) begin
            state_d = FOOD;
            valid_d = 1'b1;
            x_d     = xfood;
            y_d     = yfood;
            code_d  = CODE_FOOD;
          end else begin
            // Empty walk: nothing to emit, so go straight to the done pulse
            busy_d  = 1'b0;
            done_d  = 1'b1;
            valid_d = 1'b0;
          end
        end
      end
      SEG: begin
        if (out_ready) begin
          if (last_seg) begin
            if (food_en_q) begin
              state_d = FOOD;
              x_d     = xfood_q;
              y_d     = yfood_q;
              code_d  = CODE_FOOD;
            end else begin
              state_d = IDLE;
              valid_d = 1'b0;
              x_d     = '0;
              y_d     = '0;
              code_d  = 2'b00;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            idx_d  = idx_next;
            x_d    = seg_nxt[COORD_W-1:0];
            y_d    = seg_nxt[SEG_W-1:COORD_W];
            code_d = CODE_BODY;
          end
        end
      end
      FOOD: begin
        if (out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          x_d     = '0;
          y_d     = '0;
          code_d  = 2'b00;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any walk asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      snake_q   <= '0;
      food_en_q <= 1'b0;
      xfood_q   <= '0;
      yfood_q   <= '0;
      valid_q   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      code_q    <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      snake_q   <= snake_d;
      food_en_q <= food_en_d;
      xfood_q   <= xfood_d;
      yfood_q   <= yfood_d;
      valid_q   <= valid_d;
      x_q       <= x_d;
      y_q       <= y_d;
      code_q    <= code_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      len_err_q <= len_err_d;
    end
  end

  assign out_valid = valid_q;
  assign x_loc     = x_q;
  assign y_loc     = y_q;
  assign data_out  = code_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_snake_segment_streamer.sv
// Directed bench for snake_segment_streamer at default parameters.
// Each scenario task drives a walk, records the emitted cells and checks them inline.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_snake_segment_streamer;

  localparam int COORD_W = 4;
  localparam int MAX_LEN = 225;
  localparam int LEN_W   = 8;
  localparam int SEG_W   = 2 * COORD_W;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       start;
  logic [MAX_LEN*SEG_W-1:0]   snake_in;
  logic [LEN_W-1:0]           length;
  logic                       food_en;
  logic [COORD_W-1:0]         xfood;
  logic [COORD_W-1:0]         yfood;
  logic                       out_ready;
  logic                       out_valid;
  logic [COORD_W-1:0]         x_loc;
  logic [COORD_W-1:0]         y_loc;
  logic [1:0]                 data_out;
  logic                       busy;
  logic                       done;
  logic                       len_err;

  snake_segment_streamer #(.COORD_W(COORD_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .snake_in(snake_in), .length(length),
    .food_en(food_en), .xfood(xfood), .yfood(yfood), .out_ready(out_ready),
    .out_valid(out_valid), .x_loc(x_loc), .y_loc(y_loc), .data_out(data_out),
    .busy(busy), .done(done), .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] d;
  } cell_t;

  int    total = 0;
  int    bad   = 0;
  cell_t cells[$];
  int    done_cyc;
  int    busy_cnt;
  bit    hold_violation;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_seg(input int i, input logic [3:0] x, input logic [3:0] y);
    snake_in[i*SEG_W +: SEG_W] = {y, x};
  endtask

  // Call with start already driven high; cycle 0 is the acceptance cycle.
  // stall_cycles holds out_ready low while segment 1 is presented.
  // scramble changes every input and pulses start while the walk is busy.
  task automatic collect(input int limit, input int stall_cycles, input bit scramble);
    cell_t cur;
    cell_t prev;
    bit    prev_stalled;
    int    stall_left;
    cells.delete();
    done_cyc       = -1;
    busy_cnt       = 0;
    hold_violation = 0;
    prev_stalled   = 0;
    stall_left     = stall_cycles;
    prev           = '0;
    for (int c = 1; c <= limit && done_cyc < 0; c++) begin
      tick();
      start = 1'b0;
      if (scramble && c == 1) begin
        snake_in = '1;
        length   = 8'd0;
        xfood    = 4'd0;
        yfood    = 4'd0;
        food_en  = 1'b0;
      end
      if (scramble && c == 2) start = 1'b1;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cyc = c;
      cur = '{x: x_loc, y: y_loc, d: data_out};
      if (prev_stalled && (out_valid !== 1'b1 || cur !== prev)) hold_violation = 1;
      prev_stalled = 0;
      if (out_valid === 1'b1) begin
        if (stall_left > 0 && cells.size() == 1) begin
          out_ready    = 1'b0;
          stall_left--;
          prev_stalled = 1;
          prev         = cur;
        end else begin
          out_ready = 1'b1;
          cells.push_back(cur);
        end
      end else begin
        out_ready = 1'b1;
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic load_basic();
    snake_in = '0;
    set_seg(0, 4'd1, 4'd1);
    set_seg(1, 4'd2, 4'd1);
    set_seg(2, 4'd3, 4'd1);
    length  = 8'd3;
    food_en = 1'b1;
    xfood   = 4'd7;
    yfood   = 4'd9;
  endtask

  task automatic check_basic_cells(input string tag);
    cell_t exp[4];
    exp[0] = '{x: 4'd1, y: 4'd1, d: 2'b11};
    exp[1] = '{x: 4'd2, y: 4'd1, d: 2'b10};
    exp[2] = '{x: 4'd3, y: 4'd1, d: 2'b10};
    exp[3] = '{x: 4'd7, y: 4'd9, d: 2'b01};
    total++;
    if (cells.size() !== 4) begin
      bad++;
      $display("FAIL %s cell_count got=%0d want=4", tag, cells.size());
    end
    for (int i = 0; i < 4 && i < cells.size(); i++) begin
      total++;
      if (cells[i] !== exp[i]) begin
        bad++;
        $display("FAIL %s cell%0d got=%h want=%h", tag, i, cells[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; snake_in = '0; length = '0; food_en = 1'b0;
    xfood = '0; yfood = '0; out_ready = 1'b1;
    repeat (2) tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if ({x_loc, y_loc} !== 8'h00) begin bad++; $display("FAIL reset_xy got=%h want=00", {x_loc, y_loc}); end
    total++; if (data_out !== 2'b00) begin bad++; $display("FAIL reset_data got=%b want=00", data_out); end
    total++; if ({busy, done, len_err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, len_err}); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    load_basic();
    start = 1'b1;
    collect(20, 0, 1'b1);
    check_basic_cells("basic");
    total++; if (done_cyc !== 5) begin bad++; $display("FAIL basic_done_cycle got=%0d want=5", done_cyc); end
    total++; if (busy_cnt !== 4) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=4", busy_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b want=0", busy); end
    tick();
    total++; if ({out_valid, busy, done} !== 3'b000) begin bad++; $display("FAIL basic_idle_after got=%b want=000", {out_valid, busy, done}); end
  endtask

  task automatic test_stall();
    load_basic();
    start = 1'b1;
    collect(20, 3, 1'b0);
    check_basic_cells("stall");
    total++; if (hold_violation !== 1'b0) begin bad++; $display("FAIL stall_hold got=%b want=0", hold_violation); end
    total++; if (done_cyc !== 8) begin bad++; $display("FAIL stall_done_cycle got=%0d want=8", done_cyc); end
  endtask

  task automatic test_empty();
    length = 8'd0; food_en = 1'b0;
    start = 1'b1;
    collect(10, 0, 1'b0);
    total++; if (cells.size() !== 0) begin bad++; $display("FAIL empty_cells got=%0d want=0", cells.size()); end
    total++; if (done_cyc !== 1) begin bad++; $display("FAIL empty_done_cycle got=%0d want=1", done_cyc); end
    tick();
    length = 8'd0; food_en = 1'b1; xfood = 4'd5; yfood = 4'd12;
    start = 1'b1;
    collect(10, 0, 1'b0);
    total++; if (cells.size() !== 1) begin bad++; $display("FAIL foodonly_cells got=%0d want=1", cells.size()); end
    else begin
      total++;
      if (cells[0] !== cell_t'{x: 4'd5, y: 4'd12, d: 2'b01}) begin
        bad++; $display("FAIL foodonly_cell got=%h want=%h", cells[0], cell_t'{x: 4'd5, y: 4'd12, d: 2'b01});
      end
    end
    total++; if (done_cyc !== 2) begin bad++; $display("FAIL foodonly_done_cycle got=%0d want=2", done_cyc); end
  endtask

  task automatic test_no_food();
    snake_in = '0;
    set_seg(0, 4'd10, 4'd3);
    set_seg(1, 4'd11, 4'd3);
    length = 8'd2; food_en = 1'b0; xfood = 4'd1; yfood = 4'd1;
    start = 1'b1;
    collect(10, 0, 1'b0);
    total++; if (cells.size() !== 2) begin bad++; $display("FAIL nofood_cells got=%0d want=2", cells.size()); end
    else begin
      total++;
      if (cells[1] !== cell_t'{x: 4'd11, y: 4'd3, d: 2'b10}) begin
        bad++; $display("FAIL nofood_cell1 got=%h want=%h", cells[1], cell_t'{x: 4'd11, y: 4'd3, d: 2'b10});
      end
    end
    total++; if (done_cyc !== 3) begin bad++; $display("FAIL nofood_done_cycle got=%0d want=3", done_cyc); end
  endtask

  task automatic test_overlength();
    cell_t exp;
    int    errs;
    for (int i = 0; i < MAX_LEN; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      set_seg(i, iv[3:0], iv[7:4]);
    end
    length = 8'(MAX_LEN + 5); food_en = 1'b0;
    start = 1'b1;
    collect(400, 0, 1'b0);
    total++; if (cells.size() !== MAX_LEN) begin bad++; $display("FAIL over_cells got=%0d want=%0d", cells.size(), MAX_LEN); end
    errs = 0;
    for (int i = 0; i < cells.size(); i++) begin
      logic [7:0] iv;
      iv  = 8'(i);
      exp = '{x: iv[3:0], y: iv[7:4], d: (i == 0) ? 2'b11 : 2'b10};
      if (cells[i] !== exp) begin
        if (errs < 3) $display("FAIL over_cell%0d got=%h want=%h", i, cells[i], exp);
        errs++;
      end
    end
    total++; if (errs != 0) bad++;
    total++; if (done_cyc !== MAX_LEN + 1) begin bad++; $display("FAIL over_done_cycle got=%0d want=%0d", done_cyc, MAX_LEN + 1); end
    total++; if (len_err !== 1'b1) begin bad++; $display("FAIL over_len_err_at_done got=%b want=1", len_err); end
    tick(); tick();
    total++; if (len_err !== 1'b1) begin bad++; $display("FAIL over_len_err_sticky got=%b want=1", len_err); end
    length = 8'd2;
    start = 1'b1;
    collect(10, 0, 1'b0);
    total++; if (len_err !== 1'b0) begin bad++; $display("FAIL over_len_err_clear got=%b want=0", len_err); end
    total++; if (cells.size() !== 2) begin bad++; $display("FAIL over_followup_cells got=%0d want=2", cells.size()); end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    snake_in = '0;
    for (int i = 0; i < 5; i++) set_seg(i, 4'(i + 2), 4'(i + 8));
    length = 8'd5; food_en = 1'b1; xfood = 4'd15; yfood = 4'd15;
    start = 1'b1;
    tick(); start = 1'b0;   // cycle 1: seg0
    tick();                 // cycle 2: seg1
    tick();                 // cycle 3: seg2
    total++;
    if ({out_valid, x_loc, y_loc, data_out} !== {1'b1, 4'd4, 4'd10, 2'b10}) begin
      bad++; $display("FAIL mid_seg2 got=%b/%0d/%0d/%b want=1/4/10/10", out_valid, x_loc, y_loc, data_out);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({out_valid, x_loc, y_loc, data_out, busy, done, len_err} !== '0) begin
      bad++; $display("FAIL mid_async_clear got=%b%h%h%b%b%b%b want=all zero",
                      out_valid, x_loc, y_loc, data_out, busy, done, len_err);
    end
    tick(); tick();
    reset = 1'b1;
    saw_done = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done === 1'b1 || out_valid === 1'b1) saw_done = 1;
    end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL mid_no_done got=%b want=0", saw_done); end
    start = 1'b1;
    collect(20, 0, 1'b0);
    total++; if (cells.size() !== 6) begin bad++; $display("FAIL mid_restart_cells got=%0d want=6", cells.size()); end
    else begin
      total++;
      if (cells[0] !== cell_t'{x: 4'd2, y: 4'd8, d: 2'b11}) begin
        bad++; $display("FAIL mid_restart_head got=%h want=%h", cells[0], cell_t'{x: 4'd2, y: 4'd8, d: 2'b11});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp;
    snake_in = '0;
    set_seg(0, 4'd6, 4'd7);
    length = 8'd1; food_en = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    // start held high: head cell, done, head cell, done ...
    for (int c = 1; c <= 6; c++) begin
      tick();
      exp = (c % 2 == 1) ? 2'b10 : 2'b01;
      total++;
      if ({out_valid, done} !== exp) begin
        bad++; $display("FAIL b2b_cycle%0d valid_done got=%b want=%b", c, {out_valid, done}, exp);
      end
    end
    start = 1'b0;
    tick(); tick();
    total++; if ({out_valid, busy} !== 2'b00) begin bad++; $display("FAIL b2b_idle got=%b want=00", {out_valid, busy}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_empty();
    test_no_food();
    test_overlength();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
